// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage next-PC logic: redirect priority
// classes and default address constants.
package pc_pkg;

    typedef enum logic [2:0] {
        PRI_NONE = 3'd0,
        PRI_RET  = 3'd1,
        PRI_JMP  = 3'd2,
        PRI_BR   = 3'd3,
        PRI_EXC  = 3'd4
    } pri_e;

    localparam int unsigned PC_ADDR_W    = 32;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0004;
    localparam logic [31:0] PC_INC       = 32'h0000_0001;
    localparam int unsigned PC_RAS_DEPTH = 4;

    // The pending register only ever holds a real request, so four classes fit in two bits.
    function automatic logic [1:0] pri_to_cls(input pri_e pri);
        logic [1:0] cls;
        case (pri)
            PRI_EXC: cls = 2'd3;
            PRI_BR:  cls = 2'd2;
            PRI_JMP: cls = 2'd1;
            default: cls = 2'd0;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and the count saturates at DEPTH.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = PC_ADDR_W,
    parameter int unsigned DEPTH  = PC_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Stack update; push+pop on a non-empty stack swaps the top in place,
    // while push+pop on an empty stack behaves as a plain push.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push && pop && (cnt_q != '0)) begin
            mem_d[ptr_q] = push_addr;
        end else if (push) begin
            ptr_d        = ptr_q + PTR_W'(1);
            mem_d[ptr_d] = push_addr;
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stack state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign top_addr = mem_q[ptr_q];
    assign empty    = (cnt_q == '0);

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-stage PC register and next-PC selector with stall-time redirect capture.
// Define PC_NEXT_RAS_EN to build in the return-address stack (pc_ras).
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] INC       = ADDR_W'(PC_INC),
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC),
    parameter int unsigned       RAS_DEPTH = PC_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              exc_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              call_valid,
    input  logic [ADDR_W-1:0] call_ret_addr,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] ret_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              flush,
    output logic              ras_empty
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              pend_v_q, pend_v_d;
    logic [1:0]        pend_cls_q, pend_cls_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    pri_e              new_pri_s;
    logic [ADDR_W-1:0] new_tgt_s;
    logic [1:0]        new_cls_s;
    logic              new_req_s;
    logic [ADDR_W-1:0] pc_plus_s;
    logic [ADDR_W-1:0] ret_tgt_s;
    logic              ras_empty_s;

    assign pc_plus_s = pc_q + INC;

`ifdef PC_NEXT_RAS_EN
    logic [ADDR_W-1:0] ras_top_s;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (call_valid & ~stall),
        .pop       (ret_valid & ~stall),
        .push_addr (call_ret_addr),
        .top_addr  (ras_top_s),
        .empty     (ras_empty_s)
    );

    assign ret_tgt_s = ras_empty_s ? ret_target : ras_top_s;
`else
    logic unused_cfg_s;

    assign unused_cfg_s = ^{call_valid, call_ret_addr, 32'(RAS_DEPTH)};
    assign ras_empty_s  = 1'b1;
    assign ret_tgt_s    = ret_target;
`endif

    // Highest-priority request this cycle; returns only count while fetch runs.
    always_comb begin
        new_pri_s = PRI_NONE;
        new_tgt_s = pc_plus_s;
        if (exc_valid) begin
            new_pri_s = PRI_EXC;
            new_tgt_s = EXC_VEC;
        end else if (br_taken) begin
            new_pri_s = PRI_BR;
            new_tgt_s = br_target;
        end else if (jmp_valid) begin
            new_pri_s = PRI_JMP;
            new_tgt_s = jmp_target;
        end else if (ret_valid && !stall) begin
            new_pri_s = PRI_RET;
            new_tgt_s = ret_tgt_s;
        end else begin
            new_pri_s = PRI_NONE;
            new_tgt_s = pc_plus_s;
        end
        new_cls_s = pri_to_cls(new_pri_s);
        new_req_s = (new_pri_s != PRI_NONE);
    end

    // Next PC, flush and pending-redirect bookkeeping.
    always_comb begin
        pc_d       = pc_q;
        flush_d    = 1'b0;
        pend_v_d   = pend_v_q;
        pend_cls_d = pend_cls_q;
        pend_tgt_d = pend_tgt_q;
        if (stall) begin
            if (new_req_s && (!pend_v_q || (new_cls_s >= pend_cls_q))) begin
                pend_v_d   = 1'b1;
                pend_cls_d = new_cls_s;
                pend_tgt_d = new_tgt_s;
            end else begin
                pend_v_d = pend_v_q;
            end
        end else begin
            pend_v_d = 1'b0;
            if (pend_v_q && (!new_req_s || (pend_cls_q > new_cls_s))) begin
                pc_d    = pend_tgt_q;
                flush_d = 1'b1;
            end else if (new_req_s) begin
                pc_d    = new_tgt_s;
                flush_d = 1'b1;
            end else begin
                pc_d = pc_plus_s;
            end
        end
    end

    // PC, flush and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            flush_q    <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_cls_q <= 2'd0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            pend_v_q   <= pend_v_d;
            pend_cls_q <= pend_cls_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc        = pc_q;
    assign pc_plus   = pc_plus_s;
    assign flush     = flush_q;
    assign ras_empty = ras_empty_s;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: expected pc/flush pairs are queued as
// stimulus is driven and compared one cycle later.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, exc_valid, br_taken, jmp_valid, call_valid, ret_valid;
    logic [31:0] br_target, jmp_target, call_ret_addr, ret_target;
    logic [31:0] pc, pc_plus;
    logic        flush, ras_empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    pc_next_unit #(
        .ADDR_W    (32),
        .INC       (32'd1),
        .RESET_VEC (32'd0),
        .EXC_VEC   (32'd4),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .exc_valid     (exc_valid),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .jmp_valid     (jmp_valid),
        .jmp_target    (jmp_target),
        .call_valid    (call_valid),
        .call_ret_addr (call_ret_addr),
        .ret_valid     (ret_valid),
        .ret_target    (ret_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .flush         (flush),
        .ras_empty     (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic clr_in();
        stall = 1'b0; exc_valid = 1'b0; br_taken = 1'b0; jmp_valid = 1'b0;
        call_valid = 1'b0; ret_valid = 1'b0;
        br_target = 32'd0; jmp_target = 32'd0; call_ret_addr = 32'd0; ret_target = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_in();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (pc !== 32'd0 || flush !== 1'b0 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_state pc=%h flush=%b ras_empty=%b expected pc=0 flush=0 ras_empty=1", pc, flush, ras_empty);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{32'(i), 1'b0});
            if (i > 0) tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL seq_after_reset step %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 4; i++) begin
            clr_in();
            case (i)
                0: exp_q.push_back('{32'h5, 1'b0});
                1: begin br_taken = 1'b1; br_target = 32'h40; exp_q.push_back('{32'h40, 1'b1}); end
                2: exp_q.push_back('{32'h41, 1'b0});
                default: exp_q.push_back('{32'h42, 1'b0});
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL branch step %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 12; i++) begin
            clr_in();
            case (i)
                0:  begin stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h80; exp_q.push_back('{32'h42, 1'b0}); end
                1:  begin stall = 1'b1; br_taken = 1'b1; br_target = 32'h20; exp_q.push_back('{32'h42, 1'b0}); end
                2:  begin stall = 1'b1; exp_q.push_back('{32'h42, 1'b0}); end
                3:  exp_q.push_back('{32'h20, 1'b1});
                4:  exp_q.push_back('{32'h21, 1'b0});
                5:  begin stall = 1'b1; br_taken = 1'b1; br_target = 32'h60; exp_q.push_back('{32'h21, 1'b0}); end
                6:  begin stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h90;
                          ret_valid = 1'b1; ret_target = 32'h70; exp_q.push_back('{32'h21, 1'b0}); end
                7:  exp_q.push_back('{32'h60, 1'b1});
                8:  exp_q.push_back('{32'h61, 1'b0});
                9:  begin stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'hA0; exp_q.push_back('{32'h61, 1'b0}); end
                10: begin stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'hB0; exp_q.push_back('{32'h61, 1'b0}); end
                default: exp_q.push_back('{32'hB0, 1'b1});
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL stall step %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
    endtask

    task automatic test_pending_vs_new();
        for (int i = 0; i < 6; i++) begin
            clr_in();
            case (i)
                0: begin stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h80; exp_q.push_back('{32'hB0, 1'b0}); end
                1: begin exc_valid = 1'b1; exp_q.push_back('{32'h4, 1'b1}); end
                2: exp_q.push_back('{32'h5, 1'b0});
                3: begin stall = 1'b1; br_taken = 1'b1; br_target = 32'h200; exp_q.push_back('{32'h5, 1'b0}); end
                4: begin jmp_valid = 1'b1; jmp_target = 32'h300; exp_q.push_back('{32'h200, 1'b1}); end
                default: exp_q.push_back('{32'h201, 1'b0});
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL pending_vs_new step %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            clr_in();
            case (i)
                0: begin br_taken = 1'b1; br_target = 32'h100; exp_q.push_back('{32'h100, 1'b1}); end
                1: begin jmp_valid = 1'b1; jmp_target = 32'h200; exp_q.push_back('{32'h200, 1'b1}); end
                2: begin ret_valid = 1'b1; ret_target = 32'h300; exp_q.push_back('{32'h300, 1'b1}); end
                3: begin jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFF; exp_q.push_back('{32'hFFFF_FFFF, 1'b1}); end
                4: exp_q.push_back('{32'h0, 1'b0});
                default: exp_q.push_back('{32'h1, 1'b0});
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush || pc_plus !== e.pc + 32'd1) begin
                errors++;
                $display("FAIL back_to_back step %0d pc=%h pc_plus=%h flush=%b expected pc=%h pc_plus=%h flush=%b",
                         i, pc, pc_plus, flush, e.pc, e.pc + 32'd1, e.flush);
            end
        end
    endtask

`ifdef PC_NEXT_RAS_EN
    task automatic test_ras();
        logic [31:0] ret_pcs [5];
        ret_pcs = '{32'h14, 32'h13, 32'h12, 32'h11, 32'h99};
        for (int i = 0; i < 5; i++) begin
            clr_in();
            call_valid = 1'b1; call_ret_addr = 32'h10 + 32'(i);
            exp_q.push_back('{32'h2 + 32'(i), 1'b0});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL ras_push step %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
        checks++;
        if (ras_empty !== 1'b0) begin
            errors++;
            $display("FAIL ras_full_not_empty ras_empty=%b expected 0", ras_empty);
        end
        for (int i = 0; i < 5; i++) begin
            clr_in();
            ret_valid = 1'b1; ret_target = 32'h99;
            exp_q.push_back('{ret_pcs[i], 1'b1});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL ras_pop step %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
        clr_in();
        tick();
        checks++;
        if (ras_empty !== 1'b1 || pc !== 32'h9A) begin
            errors++;
            $display("FAIL ras_drained ras_empty=%b pc=%h expected ras_empty=1 pc=0000009a", ras_empty, pc);
        end
        for (int i = 0; i < 7; i++) begin
            clr_in();
            case (i)
                0: begin call_valid = 1'b1; call_ret_addr = 32'h10; exp_q.push_back('{32'h9B, 1'b0}); end
                1: begin call_valid = 1'b1; call_ret_addr = 32'h11; exp_q.push_back('{32'h9C, 1'b0}); end
                2: begin call_valid = 1'b1; call_ret_addr = 32'h30; ret_valid = 1'b1; ret_target = 32'h99;
                         exp_q.push_back('{32'h11, 1'b1}); end
                3: begin ret_valid = 1'b1; ret_target = 32'h99; exp_q.push_back('{32'h30, 1'b1}); end
                4: begin ret_valid = 1'b1; ret_target = 32'h99; exp_q.push_back('{32'h10, 1'b1}); end
                5: begin ret_valid = 1'b1; ret_target = 32'h99; exp_q.push_back('{32'h99, 1'b1}); end
                default: exp_q.push_back('{32'h9A, 1'b0});
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL ras_call_ret step %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
    endtask
`else
    task automatic test_ras();
        for (int i = 0; i < 3; i++) begin
            clr_in();
            case (i)
                0: begin call_valid = 1'b1; call_ret_addr = 32'h50; exp_q.push_back('{32'h2, 1'b0}); end
                1: begin ret_valid = 1'b1; ret_target = 32'h77; exp_q.push_back('{32'h77, 1'b1}); end
                default: exp_q.push_back('{32'h78, 1'b0});
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush || ras_empty !== 1'b1) begin
                errors++;
                $display("FAIL ras_off step %0d pc=%h flush=%b ras_empty=%b expected pc=%h flush=%b ras_empty=1",
                         i, pc, flush, ras_empty, e.pc, e.flush);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        clr_in();
        call_valid = 1'b1; call_ret_addr = 32'h55;
        tick();
        clr_in();
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h80;
        tick();
        clr_in();
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 32'd0 || flush !== 1'b0 || ras_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pc=%h flush=%b ras_empty=%b expected pc=0 flush=0 ras_empty=1", pc, flush, ras_empty);
        end
        tick();
        rst_n = 1'b1;
        clr_in();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                exp_q.push_back('{32'h1, 1'b0});
            end else begin
                ret_valid = 1'b1; ret_target = 32'h66;
                exp_q.push_back('{32'h66, 1'b1});
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL after_reset_mid step %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
            clr_in();
        end
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_pt, n_tgt;
        logic        m_pv, m_fl;
        int          m_pcls, n_cls;
        clr_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pc = 32'd0; m_pv = 1'b0; m_pcls = 0; m_pt = 32'd0;
        for (int i = 0; i < 300; i++) begin
            clr_in();
            stall      = ($urandom_range(2, 0) == 0);
            exc_valid  = ($urandom_range(15, 0) == 0);
            br_taken   = ($urandom_range(5, 0) == 0);
            jmp_valid  = ($urandom_range(4, 0) == 0);
            ret_valid  = ($urandom_range(4, 0) == 0);
            br_target  = $urandom;
            jmp_target = $urandom;
            ret_target = $urandom;
            if (exc_valid)                begin n_cls = 4; n_tgt = 32'h4; end
            else if (br_taken)            begin n_cls = 3; n_tgt = br_target; end
            else if (jmp_valid)           begin n_cls = 2; n_tgt = jmp_target; end
            else if (ret_valid && !stall) begin n_cls = 1; n_tgt = ret_target; end
            else                          begin n_cls = 0; n_tgt = 32'd0; end
            m_fl = 1'b0;
            if (stall) begin
                if (n_cls != 0 && (!m_pv || n_cls >= m_pcls)) begin
                    m_pv = 1'b1; m_pcls = n_cls; m_pt = n_tgt;
                end
            end else begin
                if (m_pv && m_pcls > n_cls) begin
                    m_pc = m_pt; m_fl = 1'b1;
                end else if (n_cls != 0) begin
                    m_pc = n_tgt; m_fl = 1'b1;
                end else begin
                    m_pc = m_pc + 32'd1;
                end
                m_pv = 1'b0;
            end
            exp_q.push_back('{m_pc, m_fl});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush) begin
                errors++;
                $display("FAIL random cycle %0d pc=%h flush=%b expected pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        test_reset();
        test_branch();
        test_stall();
        test_pending_vs_new();
        test_back_to_back();
        test_ras();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
